spawn_scheduler: RTL

- Controller that sequences obstacle creation for the obstacle table.
- Derives the difficulty (target active count, scroll speed) from time alive.
- Runs a randomized per-frame spawn delay, picks lane and sprite under a lane-repeat rule, and offers one spawn request at a time over a valid/ready handshake.
- Sits between the game timer and random source on one side, and the obstacle table (which owns slots and positions) on the other.

---
 rtl/spawn_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spawn_scheduler.sv
// Purpose: paces obstacle creation. It derives difficulty from time alive, runs a randomized frame delay, and picks lane and sprite.
// Latency: difficulty follows time_alive one cycle later; a request appears the cycle after the last delay frame.
// Backpressure: a request is held stable until spawn_ready accepts it, then one settle cycle passes before IDLE re-evaluates.
module spawn_scheduler #(
    parameter int MAX_OBSTACLES   = 10,
    parameter int MIN_GAP_FRAMES  = 8,
    parameter int WAIT_SHIFT      = 2,
    parameter int LANE_REPEAT_MAX = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        game_reset,
    input  logic        frame_trigger,
    input  logic [11:0] time_alive,
    input  logic [3:0]  active_count,
    input  logic [3:0]  random_num,
    input  logic [1:0]  random_lane,
    input  logic [1:0]  random_sprite,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    output logic [1:0]  spawn_sprite,
    output logic [2:0]  speed,
    output logic [3:0]  target_active,
    output logic [15:0] spawns_total
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OBSTACLES);
    localparam logic [1:0] REP_MAX = 2'(LANE_REPEAT_MAX);
    localparam logic [6:0] GAP     = 7'(MIN_GAP_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_OFFER  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t     state;
    logic [6:0] wait_cnt;
    logic [1:0] last_lane;
    logic [1:0] repeat_cnt;
    logic [1:0] cand_lane;
    logic [1:0] pick_lane;
    logic [6:0] wait_load;
    logic       clear;

    // Next lane in the 0..2 rotation.
    function automatic logic [1:0] lane_inc(input logic [1:0] l);
        return (l >= 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    assign clear     = rst_in | game_reset;
    assign wait_load = GAP + ({3'b000, random_num} << WAIT_SHIFT);

    // Lane choice: lane 3 rotates away from the last lane, and a lane used too often in a row is skipped.
    always_comb begin
        cand_lane = (random_lane == 2'd3) ? lane_inc(last_lane) : random_lane;
        pick_lane = cand_lane;
        if (cand_lane == last_lane && repeat_cnt == REP_MAX) begin
            pick_lane = lane_inc(cand_lane);
        end
    end

    // Difficulty table: the highest threshold reached sets the target count and scroll speed.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            target_active <= 4'd0;
            speed         <= 3'd1;
        end else if (time_alive >= 12'd330) begin
            target_active <= 4'd10; speed <= 3'd7;
        end else if (time_alive >= 12'd300) begin
            target_active <= 4'd9;  speed <= 3'd7;
        end else if (time_alive >= 12'd270) begin
            target_active <= 4'd8;  speed <= 3'd7;
        end else if (time_alive >= 12'd240) begin
            target_active <= 4'd7;  speed <= 3'd6;
        end else if (time_alive >= 12'd210) begin
            target_active <= 4'd6;  speed <= 3'd6;
        end else if (time_alive >= 12'd180) begin
            target_active <= 4'd5;  speed <= 3'd5;
        end else if (time_alive >= 12'd150) begin
            target_active <= 4'd4;  speed <= 3'd5;
        end else if (time_alive >= 12'd120) begin
            target_active <= 4'd3;  speed <= 3'd4;
        end else if (time_alive >= 12'd60) begin
            target_active <= 4'd2;  speed <= 3'd3;
        end else if (time_alive >= 12'd30) begin
            target_active <= 4'd1;  speed <= 3'd2;
        end else begin
            target_active <= 4'd0;  speed <= 3'd1;
        end
    end

    // Spawn sequencer: IDLE -> WAIT (frame countdown) -> OFFER (handshake) -> SETTLE -> IDLE.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            state        <= ST_IDLE;
            wait_cnt     <= 7'd0;
            last_lane    <= 2'd1;
            repeat_cnt   <= 2'd0;
            spawn_valid  <= 1'b0;
            spawn_lane   <= 2'd0;
            spawn_sprite <= 2'd0;
            spawns_total <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active_count < target_active && active_count < MAX_CNT) begin
                        wait_cnt <= wait_load;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (frame_trigger) begin
                        if (wait_cnt <= 7'd1) begin
                            wait_cnt     <= 7'd0;
                            spawn_valid  <= 1'b1;
                            spawn_lane   <= pick_lane;
                            spawn_sprite <= random_sprite;
                            state        <= ST_OFFER;
                        end else begin
                            wait_cnt <= wait_cnt - 7'd1;
                        end
                    end
                end
                ST_OFFER: begin
                    if (spawn_valid && spawn_ready) begin
                        spawn_valid <= 1'b0;
                        if (spawns_total != 16'hFFFF) begin
                            spawns_total <= spawns_total + 16'd1;
                        end
                        if (spawn_lane == last_lane) begin
                            if (repeat_cnt != REP_MAX) begin
                                repeat_cnt <= repeat_cnt + 2'd1;
                            end
                        end else begin
                            repeat_cnt <= 2'd1;
                            last_lane  <= spawn_lane;
                        end
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    spawn_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
